// File: rtl/line_xfer_master.sv
// Cache-line transfer master: moves whole lines between a cache controller and a word-wide data memory.
// Fill/write-back take N+1 cycles from accept to resp_valid, evict-then-fill 2N+1; no response backpressure.
module line_xfer_master #(
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_W         = 32 * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_victim_addr,
  input  logic [LINE_W-1:0] req_wline,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rline,
  output logic              busy,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_mask,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [31:0] LINE_OFS_MASK = 32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [1:0]         op_q;
  logic [31:0]        fill_base, victim_base;
  logic [LINE_W-1:0]  wline_q;
  logic               accept, last;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign last      = (idx == IDX_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      op_q        <= '0;
      fill_base   <= '0;
      victim_base <= '0;
      wline_q     <= '0;
      resp_rline  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        op_q        <= req_op;
        fill_base   <= req_addr & ~LINE_OFS_MASK;
        victim_base <= req_victim_addr & ~LINE_OFS_MASK;
        wline_q     <= req_wline;
      end
      if (state == READ) resp_rline[32*idx +: 32] <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          idx_nxt = '0;
          case (req_op)
            2'b00:        state_nxt = READ;
            2'b01, 2'b10: state_nxt = WRITE;
            default:      state_nxt = RESP;
          endcase
        end
      end
      WRITE: begin
        idx_nxt = idx + 1'b1;
        if (last) begin
          if (op_q == 2'b10) begin
            state_nxt = READ;
            idx_nxt   = '0;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      READ: begin
        idx_nxt = idx + 1'b1;
        if (last) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so an interrupted transfer cannot commit another word on the next negedge.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mask   = 3'b000;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    if (!reset) begin
      if (state == WRITE) begin
        mem_wr_en = 1'b1;
        mem_mask  = 3'b010;
        mem_addr  = victim_base + 32'({idx, 2'b00});
        mem_wdata = wline_q[32*idx +: 32];
      end else if (state == READ) begin
        mem_rd_en = 1'b1;
        mem_mask  = 3'b010;
        mem_addr  = fill_base + 32'({idx, 2'b00});
      end
    end
  end

  assign busy       = (state != IDLE) && !reset;
  assign resp_valid = (state == RESP) && !reset;

endmodule

// File: tb/tb_line_xfer_master.sv
// Directed bench for line_xfer_master with a behavioural word memory (combinational read, negedge write).
module tb_line_xfer_master;

  localparam int N = 4;
  localparam int LW = 32 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_victim_addr;
  logic [LW-1:0] req_wline;
  logic          resp_valid;
  logic [LW-1:0] resp_rline;
  logic          busy;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_mask;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  line_xfer_master #(.WORDS_PER_LINE(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_victim_addr(req_victim_addr), .req_wline(req_wline),
    .resp_valid(resp_valid), .resp_rline(resp_rline), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(negedge clk) if (mem_wr_en) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " wr_en"}, LW'(mem_wr_en), '0);
    check({tag, " rd_en"}, LW'(mem_rd_en), '0);
    check({tag, " mask"}, LW'(mem_mask), '0);
    check({tag, " addr"}, LW'(mem_addr), '0);
    check({tag, " wdata"}, LW'(mem_wdata), '0);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] victim, input logic [LW-1:0] wline);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_victim_addr = victim; req_wline = wline;
    #1;
    check("ready_before_accept", LW'(req_ready), LW'(1'b1));
    tick();
    req_valid = 1'b0;
  endtask

  logic [LW-1:0] fill_line, wb_line, ef_line, ef_fill;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h11; mem[(32'h104) >> 2] = 32'h22;
    mem[32'h108 >> 2] = 32'h33; mem[(32'h10C) >> 2] = 32'h44;
    for (int i = 0; i < 4; i++) mem[(32'h80 >> 2) + i] = 32'hA0 + i;
    for (int i = 0; i < 4; i++) mem[10'h3FC + i] = 32'hF000_0000 + i;
    fill_line = {32'h44, 32'h33, 32'h22, 32'h11};
    wb_line   = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    ef_line   = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
    ef_fill   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_addr = '0; req_victim_addr = '0; req_wline = '0;
    tick(); tick();
    check("rst_ready", LW'(req_ready), '0);
    check("rst_busy", LW'(busy), '0);
    check("rst_resp_valid", LW'(resp_valid), '0);
    check("rst_rline", resp_rline, '0);
    check_idle_outputs("rst");
    reset = 1'b0;
    #1;
    check("post_rst_ready", LW'(req_ready), LW'(1'b1));

    // Fill of the line containing 0x104
    send(2'b00, 32'h104, 32'h0, '0);
    for (int i = 0; i < N; i++) begin
      check("fill_rd_en", LW'(mem_rd_en), LW'(1'b1));
      check("fill_wr_en", LW'(mem_wr_en), '0);
      check("fill_mask", LW'(mem_mask), LW'(3'b010));
      check("fill_addr", LW'(mem_addr), LW'(32'h100 + 4 * i));
      check("fill_ready_low", LW'(req_ready), '0);
      check("fill_no_resp", LW'(resp_valid), '0);
      tick();
    end
    check("fill_resp_valid_c5", LW'(resp_valid), LW'(1'b1));
    check("fill_rline", resp_rline, fill_line);
    check_idle_outputs("fill_resp");
    tick();
    check("fill_resp_pulse", LW'(resp_valid), '0);
    check("fill_idle_busy", LW'(busy), '0);

    // Write-back to 0x200
    send(2'b01, 32'h0, 32'h200, wb_line);
    for (int i = 0; i < N; i++) begin
      check("wb_wr_en", LW'(mem_wr_en), LW'(1'b1));
      check("wb_rd_en", LW'(mem_rd_en), '0);
      check("wb_addr", LW'(mem_addr), LW'(32'h200 + 4 * i));
      check("wb_wdata", LW'(mem_wdata), LW'(wb_line[32*i +: 32]));
      tick();
    end
    check("wb_resp_valid_c5", LW'(resp_valid), LW'(1'b1));
    check("wb_rline_unchanged", resp_rline, fill_line);
    tick();
    for (int i = 0; i < N; i++)
      check("wb_mem_readback", LW'(mem[(32'h200 >> 2) + i]), LW'(wb_line[32*i +: 32]));

    // Evict 0x40 then fill 0x80
    send(2'b10, 32'h80, 32'h40, ef_line);
    for (int c = 1; c <= 2 * N; c++) begin
      check("ef_no_overlap", LW'(mem_wr_en & mem_rd_en), '0);
      check("ef_no_resp", LW'(resp_valid), '0);
      if (c <= N) begin
        check("ef_wr_en", LW'(mem_wr_en), LW'(1'b1));
        check("ef_wr_addr", LW'(mem_addr), LW'(32'h40 + 4 * (c - 1)));
      end else begin
        check("ef_rd_en", LW'(mem_rd_en), LW'(1'b1));
        check("ef_rd_addr", LW'(mem_addr), LW'(32'h80 + 4 * (c - 1 - N)));
      end
      tick();
    end
    check("ef_resp_valid_c9", LW'(resp_valid), LW'(1'b1));
    check("ef_rline", resp_rline, ef_fill);
    tick();
    check("ef_victim_mem", LW'(mem[(32'h40 >> 2) + 3]), LW'(32'h5555_0004));

    // Back-to-back: request held high across a fill
    req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h100;
    #1;
    tick();
    for (int c = 1; c <= N + 1; c++) begin
      check("b2b_ready_low", LW'(req_ready), '0);
      check("b2b_busy", LW'(busy), LW'(1'b1));
      tick();
    end
    check("b2b_idle_ready", LW'(req_ready), LW'(1'b1));
    check("b2b_idle_no_rd", LW'(mem_rd_en), '0);
    tick();
    req_valid = 1'b0;
    check("b2b_second_accepted", LW'(mem_rd_en), LW'(1'b1));
    check("b2b_second_addr", LW'(mem_addr), LW'(32'h100));
    for (int c = 0; c < N + 1; c++) tick();
    check("b2b_done_idle", LW'(busy), '0);

    // Reset during the third word of a write-back to 0x300
    send(2'b01, 32'h0, 32'h300, wb_line);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("mrst_wr_en", LW'(mem_wr_en), '0);
    check("mrst_busy", LW'(busy), '0);
    check_idle_outputs("mrst");
    tick();
    reset = 1'b0;
    #1;
    check("mrst_ready", LW'(req_ready), LW'(1'b1));
    check("mrst_rline_cleared", resp_rline, '0);
    for (int c = 0; c < 3; c++) begin
      check("mrst_no_resp", LW'(resp_valid), '0);
      check("mrst_no_access", LW'(mem_wr_en | mem_rd_en), '0);
      tick();
    end
    check("mrst_word0", LW'(mem[32'h300 >> 2]), LW'(32'hAAAA_0001));
    check("mrst_word1", LW'(mem[(32'h300 >> 2) + 1]), LW'(32'hBBBB_0002));
    check("mrst_word2_unwritten", LW'(mem[(32'h300 >> 2) + 2]), '0);

    // Reserved op: immediate response, no memory activity
    send(2'b11, 32'h80, 32'h40, ef_line);
    check("op11_resp_valid", LW'(resp_valid), LW'(1'b1));
    check("op11_rline_unchanged", resp_rline, '0);
    check_idle_outputs("op11");
    tick();
    check("op11_idle", LW'(busy), '0);

    // Fill wrapping at the top of the address space
    send(2'b00, 32'hFFFF_FFF4, 32'h0, '0);
    for (int i = 0; i < N; i++) begin
      check("wrap_addr", LW'(mem_addr), LW'(32'hFFFF_FFF0 + 4 * i));
      tick();
    end
    check("wrap_resp_valid", LW'(resp_valid), LW'(1'b1));
    check("wrap_rline", resp_rline,
          {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
